mem_access_unit: RTL and testbench

- Parametrised successor to the combinational memory-control decode. Sits between the execute stage and the dmem/imem BRAMs and the IO bus.
- Decodes the target region and generates byte-lane write enables for XLEN/8 lanes. It also aligns store data and aligns plus sign/zero-extends load data.
- Runs a small FSM that sequences the 1-cycle BRAM load latency and a handshaked, timeout-guarded IO access.
- It stalls the pipeline while an IO access is outstanding.

---
 rtl/mem_access_pkg.sv | 29 ++
 rtl/mem_access_unit_load_align.sv | 43 ++++
 rtl/mem_access_unit.sv | 255 +++++++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory access unit: instruction opcodes,
// funct3 size/sign codes, the IO region nibble and the control FSM states.
package mem_access_pkg;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [2:0] F3_SB  = 3'd0;
    localparam logic [2:0] F3_SH  = 3'd1;
    localparam logic [2:0] F3_SW  = 3'd2;
    localparam logic [2:0] F3_SD  = 3'd3;
    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;
    localparam logic [2:0] F3_LWU = 3'd6;

    // Top address nibble that selects the IO bus
    localparam logic [3:0] REGION_IO = 4'b1000;

    typedef enum logic [1:0] {
        IDLE,
        LD_RESP,
        IO_WAIT,
        ST_SPLIT
    } state_t;

endpackage

// File: rtl/mem_access_unit_load_align.sv
// load_align: right-justifies the addressed bytes of a read word and
// sign- or zero-extends them according to funct3 (bit 2 set = unsigned).
// Ports:
//   rdata  - raw read word from dmem or IO
//   off    - byte offset of the access within the word
//   funct3 - access size and signedness
//   data   - aligned, extended result
module load_align
    import mem_access_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned OFF_W = 2
) (
    input  logic [XLEN-1:0]  rdata,
    input  logic [OFF_W-1:0] off,
    input  logic [2:0]       funct3,
    output logic [XLEN-1:0]  data
);

    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] top;
    logic [6:0]      sh;

    // Move the field to the top of the word, then shift back down so an
    // arithmetic shift does the sign extension for any access size.
    always_comb begin
        sh = 7'd0;
        case (funct3)
            F3_LB, F3_LBU: sh = 7'(XLEN - 8);
            F3_LH, F3_LHU: sh = 7'(XLEN - 16);
            F3_LW, F3_LWU: sh = 7'(XLEN - 32);
            default:       sh = 7'd0;
        endcase
        shifted = rdata >> {off, 3'b000};
        top     = shifted << sh;
        if (funct3[2]) begin
            data = top >> sh;
        end else begin
            data = XLEN'($signed(top) >>> sh);
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: region decode, byte-lane enables, store/load alignment
// and a small FSM sequencing BRAM load latency and handshaked IO accesses.
// Build option: MEM_ACCESS_MISALIGN_SPLIT_EN splits word-crossing misaligned
// dmem stores into two writes instead of dropping them.
// Ports:
//   clk, rst             - clock, synchronous active-high reset
//   req_valid, opcode,
//   funct3, addr, wdata  - memory instruction from execute
//   stall                - hold the pipeline
//   dmem_we, imem_we     - BRAM lane write enables
//   mem_wdata            - lane-aligned store data (dmem, imem, IO)
//   dmem_rdata           - BRAM read data, one cycle after the address
//   io_valid, io_we      - IO request and lane enables (zero = read)
//   io_ready, io_rdata   - IO completion and read data
//   load_valid, load_data- aligned, extended load result
//   io_err               - pulse on IO timeout
//   misaligned           - pulse on a dropped misaligned access
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned IO_TIMEOUT = 255,
    parameter int unsigned CNT_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [6:0]        opcode,
    input  logic [2:0]        funct3,
    input  logic [XLEN-1:0]   addr,
    input  logic [XLEN-1:0]   wdata,
    output logic              stall,
    output logic [XLEN/8-1:0] dmem_we,
    output logic [XLEN/8-1:0] imem_we,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic [XLEN-1:0]   dmem_rdata,
    output logic              io_valid,
    output logic [XLEN/8-1:0] io_we,
    input  logic              io_ready,
    input  logic [XLEN-1:0]   io_rdata,
    output logic              load_valid,
    output logic [XLEN-1:0]   load_data,
    output logic              io_err,
    output logic              misaligned
);

    localparam int unsigned NB    = XLEN / 8;
    localparam int unsigned OFF_W = $clog2(NB);
    localparam int unsigned LW2   = 2 * NB;
    localparam int unsigned XLEN2 = 2 * XLEN;
`ifdef MEM_ACCESS_MISALIGN_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [OFF_W-1:0] off_q, off_d;
    logic [2:0]       f3_q, f3_d;
    logic             ld_zero_q, ld_zero_d;
    logic             io_rd_q, io_rd_d;
    logic [NB-1:0]    io_lanes_q, io_lanes_d;
    logic [XLEN-1:0]  io_wdata_q, io_wdata_d;
    logic [NB-1:0]    split_we_q, split_we_d;
    logic [XLEN-1:0]  split_wdata_q, split_wdata_d;

    logic [3:0]       region;
    logic             hit_dmem, hit_imem, hit_io;
    logic             is_load, is_store, mis, split_ok, accept;
    logic [OFF_W-1:0] off;
    logic [LW2-1:0]   base_mask, lanes_w;
    logic [XLEN2-1:0] data_w;
    logic [NB-1:0]    lanes_lo, lanes_hi;
    logic [XLEN-1:0]  data_lo, data_hi;
    logic [XLEN-1:0]  align_src, aligned;
    logic             unused_addr;

    assign region      = addr[XLEN-1 -: 4];
    assign hit_dmem    = ~region[3] & region[0];
    assign hit_imem    = ~region[3] & region[1];
    assign hit_io      = (region == REGION_IO);
    assign is_load     = (opcode == OP_LOAD);
    assign is_store    = (opcode == OP_STORE);
    assign off         = addr[OFF_W-1:0];
    assign split_ok    = SPLIT_EN && is_store && hit_dmem;
    assign unused_addr = ^addr[XLEN-5:OFF_W];

    // Lane mask and alignment check per access size
    always_comb begin
        base_mask = '0;
        mis       = 1'b0;
        case ({1'b0, funct3[1:0]})
            F3_SB: base_mask = LW2'(1);
            F3_SH: begin
                base_mask = LW2'(3);
                mis       = addr[0];
            end
            F3_SW: begin
                base_mask = LW2'(15);
                mis       = (addr[1:0] != 2'b00);
            end
            F3_SD: begin
                if (XLEN == 64) begin
                    base_mask = LW2'(255);
                    mis       = (addr[2:0] != 3'b000);
                end else begin
                    base_mask = LW2'(15);
                    mis       = (addr[1:0] != 2'b00);
                end
            end
            default: ;
        endcase
    end

    // Double-width shifts keep the lanes that spill into the next word
    assign lanes_w  = base_mask << off;
    assign data_w   = XLEN2'(wdata) << {off, 3'b000};
    assign lanes_lo = lanes_w[NB-1:0];
    assign lanes_hi = lanes_w[LW2-1:NB];
    assign data_lo  = data_w[XLEN-1:0];
    assign data_hi  = data_w[XLEN2-1:XLEN];

    assign align_src = (state_q == IO_WAIT) ? io_rdata : dmem_rdata;

    load_align #(
        .XLEN  (XLEN),
        .OFF_W (OFF_W)
    ) u_load_align (
        .rdata  (align_src),
        .off    (off_q),
        .funct3 (f3_q),
        .data   (aligned)
    );

    // State and captured-request registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            off_q         <= '0;
            f3_q          <= '0;
            ld_zero_q     <= 1'b0;
            io_rd_q       <= 1'b0;
            io_lanes_q    <= '0;
            io_wdata_q    <= '0;
            split_we_q    <= '0;
            split_wdata_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            off_q         <= off_d;
            f3_q          <= f3_d;
            ld_zero_q     <= ld_zero_d;
            io_rd_q       <= io_rd_d;
            io_lanes_q    <= io_lanes_d;
            io_wdata_q    <= io_wdata_d;
            split_we_q    <= split_we_d;
            split_wdata_q <= split_wdata_d;
        end
    end

    // Next-state and outputs; everything is held at zero while in reset
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        off_d         = off_q;
        f3_d          = f3_q;
        ld_zero_d     = ld_zero_q;
        io_rd_d       = io_rd_q;
        io_lanes_d    = io_lanes_q;
        io_wdata_d    = io_wdata_q;
        split_we_d    = split_we_q;
        split_wdata_d = split_wdata_q;
        accept        = 1'b0;
        stall         = 1'b0;
        dmem_we       = '0;
        imem_we       = '0;
        mem_wdata     = '0;
        io_valid      = 1'b0;
        io_we         = '0;
        load_valid    = 1'b0;
        load_data     = '0;
        io_err        = 1'b0;
        misaligned    = 1'b0;

        if (!rst) begin
            case (state_q)
                IDLE: accept = 1'b1;
                LD_RESP: begin
                    load_valid = 1'b1;
                    load_data  = ld_zero_q ? '0 : aligned;
                    state_d    = IDLE;
                    accept     = 1'b1;
                end
                IO_WAIT: begin
                    stall     = 1'b1;
                    io_valid  = 1'b1;
                    io_we     = io_lanes_q;
                    mem_wdata = io_wdata_q;
                    cnt_d     = cnt_q + CNT_W'(1);
                    if (io_ready) begin
                        state_d = IDLE;
                        if (io_rd_q) begin
                            load_valid = 1'b1;
                            load_data  = aligned;
                        end
                    end else if (cnt_q == CNT_W'(IO_TIMEOUT - 1)) begin
                        io_err     = 1'b1;
                        state_d    = IDLE;
                        load_valid = io_rd_q;
                    end
                end
                ST_SPLIT: begin
                    // Second half of a word-crossing store, next dmem word
                    stall     = 1'b1;
                    dmem_we   = split_we_q;
                    mem_wdata = split_wdata_q;
                    state_d   = IDLE;
                end
                default: state_d = IDLE;
            endcase

            if (accept && req_valid && (is_load || is_store)) begin
                if (mis && !split_ok) begin
                    misaligned = 1'b1;
                end else if (hit_io) begin
                    state_d    = IO_WAIT;
                    cnt_d      = '0;
                    off_d      = off;
                    f3_d       = funct3;
                    io_rd_d    = is_load;
                    io_lanes_d = is_store ? lanes_lo : '0;
                    io_wdata_d = data_lo;
                    stall      = 1'b1;
                end else if (is_load) begin
                    state_d   = LD_RESP;
                    off_d     = off;
                    f3_d      = funct3;
                    ld_zero_d = ~hit_dmem;
                end else begin
                    dmem_we   = hit_dmem ? lanes_lo : '0;
                    imem_we   = (hit_imem && !mis) ? lanes_lo : '0;
                    mem_wdata = data_lo;
                    if (split_ok && (lanes_hi != '0)) begin
                        state_d       = ST_SPLIT;
                        split_we_d    = lanes_hi;
                        split_wdata_d = data_hi;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit (XLEN=32, IO_TIMEOUT=4).
module tb_mem_access_unit;

    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_ALU = 7'b0110011;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic        stall;
    logic [3:0]  dmem_we, imem_we, io_we;
    logic [31:0] mem_wdata, dmem_rdata, io_rdata, load_data;
    logic        io_valid, io_ready, load_valid, io_err, misaligned;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.XLEN(32), .IO_TIMEOUT(4), .CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .opcode     (opcode),
        .funct3     (funct3),
        .addr       (addr),
        .wdata      (wdata),
        .stall      (stall),
        .dmem_we    (dmem_we),
        .imem_we    (imem_we),
        .mem_wdata  (mem_wdata),
        .dmem_rdata (dmem_rdata),
        .io_valid   (io_valid),
        .io_we      (io_we),
        .io_ready   (io_ready),
        .io_rdata   (io_rdata),
        .load_valid (load_valid),
        .load_data  (load_data),
        .io_err     (io_err),
        .misaligned (misaligned)
    );

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic req(input logic [6:0] op, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
        req_valid = 1'b1;
        opcode    = op;
        funct3    = f3;
        addr      = a;
        wdata     = wd;
    endtask

    task automatic no_req();
        req_valid = 1'b0;
        opcode    = 7'd0;
        funct3    = 3'd0;
        addr      = 32'd0;
        wdata     = 32'd0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        io_ready = 1'b0;
        io_rdata = 32'd0;
        dmem_rdata = 32'd0;
        req(OP_ST, 3'd2, 32'h1000_0000, 32'hFFFF_FFFF);
        tick(); tick();
        #1;
        checks++; if (dmem_we !== 4'b0000) begin failures++; $display("FAIL rst_dmem_we got=%b exp=0000", dmem_we); end
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL rst_stall got=%b exp=0", stall); end
        checks++; if (mem_wdata !== 32'd0) begin failures++; $display("FAIL rst_wdata got=%h exp=0", mem_wdata); end
        tick();
        rst = 1'b0;
        no_req();
        #1;
        checks++; if (io_valid !== 1'b0 || load_valid !== 1'b0) begin failures++; $display("FAIL rst_idle got io_valid=%b load_valid=%b exp=0/0", io_valid, load_valid); end
    endtask

    task automatic test_store();
        tick(); req(OP_ST, 3'd0, 32'h1000_0003, 32'h0000_00AB); #1;
        checks++; if (dmem_we !== 4'b1000) begin failures++; $display("FAIL sb_we got=%b exp=1000", dmem_we); end
        checks++; if (mem_wdata !== 32'hAB00_0000) begin failures++; $display("FAIL sb_wdata got=%h exp=ab000000", mem_wdata); end
        checks++; if (stall !== 1'b0 || imem_we !== 4'b0000) begin failures++; $display("FAIL sb_stall_imem got=%b/%b exp=0/0000", stall, imem_we); end
        tick(); req(OP_ST, 3'd2, 32'h3000_0000, 32'h1122_3344); #1;
        checks++; if (dmem_we !== 4'b1111 || imem_we !== 4'b1111) begin failures++; $display("FAIL sw_both got=%b/%b exp=1111/1111", dmem_we, imem_we); end
        tick(); req(OP_ST, 3'd1, 32'h2000_0002, 32'h0000_BEEF); #1;
        checks++; if (imem_we !== 4'b1100 || dmem_we !== 4'b0000) begin failures++; $display("FAIL sh_imem got=%b/%b exp=1100/0000", imem_we, dmem_we); end
        checks++; if (mem_wdata !== 32'hBEEF_0000) begin failures++; $display("FAIL sh_wdata got=%h exp=beef0000", mem_wdata); end
        tick(); req(OP_ALU, 3'd2, 32'h1000_0000, 32'h5555_5555); #1;
        checks++; if (dmem_we !== 4'b0000 || misaligned !== 1'b0) begin failures++; $display("FAIL alu_ignored got=%b/%b exp=0000/0", dmem_we, misaligned); end
        tick(); no_req();
    endtask

    task automatic test_load();
        tick(); req(OP_LD, 3'd1, 32'h1000_0002, 32'd0); #1;
        checks++; if (load_valid !== 1'b0 || stall !== 1'b0) begin failures++; $display("FAIL lh_req got=%b/%b exp=0/0", load_valid, stall); end
        tick(); no_req(); dmem_rdata = 32'h8001_0000; #1;
        checks++; if (load_valid !== 1'b1 || load_data !== 32'hFFFF_8001) begin failures++; $display("FAIL lh_data got=%b/%h exp=1/ffff8001", load_valid, load_data); end
        tick(); req(OP_LD, 3'd5, 32'h1000_0002, 32'd0);
        tick(); no_req(); #1;
        checks++; if (load_valid !== 1'b1 || load_data !== 32'h0000_8001) begin failures++; $display("FAIL lhu_data got=%b/%h exp=1/00008001", load_valid, load_data); end
        tick(); req(OP_LD, 3'd0, 32'h1000_0001, 32'd0);
        tick(); no_req(); dmem_rdata = 32'h0000_FE00; #1;
        checks++; if (load_data !== 32'hFFFF_FFFE) begin failures++; $display("FAIL lb_data got=%h exp=fffffffe", load_data); end
        tick(); #1;
        checks++; if (load_valid !== 1'b0) begin failures++; $display("FAIL ld_single got=%b exp=0", load_valid); end
    endtask

    task automatic test_back_to_back();
        tick(); req(OP_LD, 3'd1, 32'h1000_0002, 32'd0);
        tick(); req(OP_LD, 3'd4, 32'h1000_0003, 32'd0); dmem_rdata = 32'h8001_0000; #1;
        checks++; if (load_valid !== 1'b1 || load_data !== 32'hFFFF_8001) begin failures++; $display("FAIL b2b_first got=%b/%h exp=1/ffff8001", load_valid, load_data); end
        tick(); no_req(); dmem_rdata = 32'h9A00_0000; #1;
        checks++; if (load_valid !== 1'b1 || load_data !== 32'h0000_009A) begin failures++; $display("FAIL b2b_second got=%b/%h exp=1/0000009a", load_valid, load_data); end
    endtask

    task automatic test_unmapped_load();
        tick(); req(OP_LD, 3'd2, 32'h0000_0000, 32'd0);
        tick(); no_req(); dmem_rdata = 32'hDEAD_BEEF; #1;
        checks++; if (load_valid !== 1'b1 || load_data !== 32'd0) begin failures++; $display("FAIL unmapped_ld got=%b/%h exp=1/00000000", load_valid, load_data); end
        tick(); req(OP_LD, 3'd2, 32'h2000_0000, 32'd0);
        tick(); no_req(); #1;
        checks++; if (load_valid !== 1'b1 || load_data !== 32'd0) begin failures++; $display("FAIL imem_ld got=%b/%h exp=1/00000000", load_valid, load_data); end
    endtask

    task automatic test_io_store();
        tick(); io_ready = 1'b0; req(OP_ST, 3'd2, 32'h8000_0010, 32'h1234_5678); #1;
        checks++; if (stall !== 1'b1 || io_valid !== 1'b0 || dmem_we !== 4'b0000) begin failures++; $display("FAIL io_st_req got=%b/%b/%b exp=1/0/0000", stall, io_valid, dmem_we); end
        for (int i = 1; i <= 3; i++) begin
            tick(); no_req(); io_ready = (i == 3); #1;
            checks++; if (stall !== 1'b1 || io_valid !== 1'b1 || io_err !== 1'b0) begin failures++; $display("FAIL io_st_wait[%0d] got=%b/%b/%b exp=1/1/0", i, stall, io_valid, io_err); end
            checks++; if (io_we !== 4'b1111 || mem_wdata !== 32'h1234_5678) begin failures++; $display("FAIL io_st_bus[%0d] got=%b/%h exp=1111/12345678", i, io_we, mem_wdata); end
        end
        checks++; if (load_valid !== 1'b0) begin failures++; $display("FAIL io_st_noload got=%b exp=0", load_valid); end
        tick(); io_ready = 1'b0; #1;
        checks++; if (stall !== 1'b0 || io_valid !== 1'b0) begin failures++; $display("FAIL io_st_done got=%b/%b exp=0/0", stall, io_valid); end
    endtask

    task automatic test_io_timeout();
        tick(); io_rdata = 32'hFFFF_FFFF; req(OP_LD, 3'd2, 32'h8000_0000, 32'd0); #1;
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL to_req_stall got=%b exp=1", stall); end
        for (int i = 1; i <= 4; i++) begin
            tick(); no_req(); #1;
            checks++; if (stall !== 1'b1 || io_valid !== 1'b1 || io_we !== 4'b0000) begin failures++; $display("FAIL to_wait[%0d] got=%b/%b/%b exp=1/1/0000", i, stall, io_valid, io_we); end
            checks++; if (io_err !== (i == 4) || load_valid !== (i == 4)) begin failures++; $display("FAIL to_err[%0d] got=%b/%b exp=%b/%b", i, io_err, load_valid, (i == 4), (i == 4)); end
        end
        checks++; if (load_data !== 32'd0) begin failures++; $display("FAIL to_data got=%h exp=00000000", load_data); end
        tick(); #1;
        checks++; if (stall !== 1'b0 || io_err !== 1'b0 || io_valid !== 1'b0) begin failures++; $display("FAIL to_done got=%b/%b/%b exp=0/0/0", stall, io_err, io_valid); end
    endtask

    task automatic test_io_read();
        tick(); req(OP_LD, 3'd0, 32'h8000_0001, 32'd0);
        tick(); no_req(); io_ready = 1'b1; io_rdata = 32'h0000_8000; #1;
        checks++; if (load_valid !== 1'b1 || load_data !== 32'hFFFF_FF80) begin failures++; $display("FAIL io_lb got=%b/%h exp=1/ffffff80", load_valid, load_data); end
        tick(); io_ready = 1'b0; #1;
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL io_lb_done got=%b exp=0", stall); end
        req(OP_LD, 3'd4, 32'h8000_0001, 32'd0);
        for (int i = 1; i <= 4; i++) begin
            tick(); no_req(); io_ready = (i == 4); #1;
        end
        checks++; if (io_err !== 1'b0 || load_valid !== 1'b1 || load_data !== 32'h0000_0080) begin failures++; $display("FAIL io_ready_wins got=%b/%b/%h exp=0/1/00000080", io_err, load_valid, load_data); end
        tick(); io_ready = 1'b0;
    endtask

    task automatic test_misaligned();
        tick(); req(OP_ST, 3'd2, 32'h1000_0002, 32'hAABB_CCDD); #1;
`ifdef MEM_ACCESS_MISALIGN_SPLIT_EN
        checks++; if (dmem_we !== 4'b1100 || mem_wdata !== 32'hCCDD_0000) begin failures++; $display("FAIL split_lo got=%b/%h exp=1100/ccdd0000", dmem_we, mem_wdata); end
        checks++; if (misaligned !== 1'b0 || stall !== 1'b0) begin failures++; $display("FAIL split_lo_flags got=%b/%b exp=0/0", misaligned, stall); end
        tick(); no_req(); #1;
        checks++; if (dmem_we !== 4'b0011 || mem_wdata !== 32'h0000_AABB || stall !== 1'b1) begin failures++; $display("FAIL split_hi got=%b/%h/%b exp=0011/0000aabb/1", dmem_we, mem_wdata, stall); end
`else
        checks++; if (dmem_we !== 4'b0000 || imem_we !== 4'b0000 || misaligned !== 1'b1) begin failures++; $display("FAIL mis_sw got=%b/%b/%b exp=0000/0000/1", dmem_we, imem_we, misaligned); end
        tick(); no_req(); #1;
        checks++; if (misaligned !== 1'b0 || dmem_we !== 4'b0000) begin failures++; $display("FAIL mis_sw_after got=%b/%b exp=0/0000", misaligned, dmem_we); end
`endif
        tick(); #1;
        checks++; if (stall !== 1'b0 || dmem_we !== 4'b0000) begin failures++; $display("FAIL mis_idle got=%b/%b exp=0/0000", stall, dmem_we); end
        req(OP_LD, 3'd1, 32'h1000_0001, 32'd0); #1;
        checks++; if (misaligned !== 1'b1) begin failures++; $display("FAIL mis_lh got=%b exp=1", misaligned); end
        tick(); no_req(); #1;
        checks++; if (load_valid !== 1'b0) begin failures++; $display("FAIL mis_lh_drop got=%b exp=0", load_valid); end
    endtask

    task automatic test_reset_mid_io();
        tick(); req(OP_ST, 3'd2, 32'h8000_0000, 32'h0BAD_F00D);
        tick(); no_req(); #1;
        checks++; if (io_valid !== 1'b1) begin failures++; $display("FAIL rmid_active got=%b exp=1", io_valid); end
        tick(); rst = 1'b1;
        tick(); rst = 1'b0; io_ready = 1'b1; #1;
        checks++; if (io_valid !== 1'b0 || stall !== 1'b0 || load_valid !== 1'b0 || io_err !== 1'b0) begin failures++; $display("FAIL rmid_after got=%b/%b/%b/%b exp=0/0/0/0", io_valid, stall, load_valid, io_err); end
        tick(); io_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        no_req();
        test_reset();
        test_store();
        test_load();
        test_back_to_back();
        test_unmapped_load();
        test_io_store();
        test_io_timeout();
        test_io_read();
        test_misaligned();
        test_reset_mid_io();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
